pipe_out_fifo: RTL and testbench

//   Word FIFO between the LFSR/counter source and the okPipeOut endpoint (addr 0xA0).

---
 rtl/pipe_out_fifo.sv | 108 ++++++++++
 tb/tb_pipe_out_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_fifo.sv
// Word FIFO feeding the okPipeOut endpoint: the source pushes with valid/ready and
// the host pops with ep_read. Pops from empty return a marker word and are counted.
module pipe_out_fifo #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned AW             = $clog2(DEPTH),
  parameter int unsigned AFULL_LEVEL    = DEPTH - 4,
  parameter logic [31:0] UNDERFLOW_WORD = 32'hDEAD_BEEF
) (
  input  logic          okClk,
  input  logic          reset_n,
  input  logic [31:0]   src_data,
  input  logic          src_valid,
  output logic          src_ready,
  input  logic          ep_read,
  output logic [31:0]   ep_datain,
  input  logic          flush,
  input  logic          clear_err,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          underflow,
  output logic [15:0]   underflow_cnt
);

  localparam int unsigned PW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic [31:0]   ep_datain_q, ep_datain_d;
  logic          src_ready_q, src_ready_d;
  logic          afull_q, afull_d;
  logic          uf_q, uf_d;
  logic [15:0]   uf_cnt_q, uf_cnt_d;
  logic          empty;
  logic          push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // src_ready_q always mirrors ~full of the registered pointers.
  assign push  = src_valid & src_ready_q;

  // Next-state: flush beats push/pop; clear_err beats a coincident underflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ep_datain_d = ep_datain_q;
    uf_d        = uf_q;
    uf_cnt_d    = uf_cnt_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (ep_read) begin
        if (empty) begin
          ep_datain_d = UNDERFLOW_WORD;
          uf_d        = 1'b1;
          if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
        end else begin
          ep_datain_d = mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d    = rd_ptr_q + PW'(1);
        end
      end
    end
    if (clear_err) begin
      uf_d     = 1'b0;
      uf_cnt_d = 16'd0;
    end
    level_d     = wr_ptr_d - rd_ptr_d;
    afull_d     = (level_d >= PW'(AFULL_LEVEL));
    src_ready_d = ~((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                    (wr_ptr_d[AW] != rd_ptr_d[AW]));
  end

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ep_datain_q <= '0;
      src_ready_q <= 1'b1;
      afull_q     <= 1'b0;
      uf_q        <= 1'b0;
      uf_cnt_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ep_datain_q <= ep_datain_d;
      src_ready_q <= src_ready_d;
      afull_q     <= afull_d;
      uf_q        <= uf_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  // Storage is not reset; a flushed push is never written.
  always_ff @(posedge okClk) begin
    if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= src_data;
  end

  assign src_ready     = src_ready_q;
  assign ep_datain     = ep_datain_q;
  assign level         = level_q;
  assign almost_full   = afull_q;
  assign underflow     = uf_q;
  assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Randomised directed bench for pipe_out_fifo against a queue-based reference model.
module tb_pipe_out_fifo;

  logic        okClk = 1'b0;
  logic        reset_n;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        ep_read;
  logic [31:0] ep_datain;
  logic        flush;
  logic        clear_err;
  logic [4:0]  level;
  logic        almost_full;
  logic        underflow;
  logic [15:0] underflow_cnt;

  pipe_out_fifo dut (
    .okClk(okClk), .reset_n(reset_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .ep_read(ep_read), .ep_datain(ep_datain), .flush(flush),
    .clear_err(clear_err), .level(level), .almost_full(almost_full),
    .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 okClk = ~okClk;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  logic [31:0] q[$];
  logic [31:0] m_dout = 32'h0;
  logic        m_uf = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(q.size()));
    chk("src_ready", 32'(src_ready), 32'(q.size() < 16));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 12));
    chk("ep_datain", ep_datain, m_dout);
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = 32'h0;
    m_uf   = 1'b0;
    m_cnt  = 0;
  endtask

  // One clock: the model consumes the inputs set before the edge, then outputs are compared.
  task automatic step();
    bit pushok;
    pushok = src_valid && (q.size() < 16);
    @(posedge okClk);
    if (flush) begin
      q.delete();
    end else begin
      if (ep_read) begin
        if (q.size() > 0) m_dout = q.pop_front();
        else begin
          m_dout = 32'hDEAD_BEEF;
          m_uf   = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (pushok) q.push_back(src_data);
    end
    if (clear_err) begin
      m_uf  = 1'b0;
      m_cnt = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    src_valid = 1'b0; ep_read = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  initial begin
    int n_push;
    int budget;
    logic [31:0] held;

    idle();
    src_data = '0;
    reset_n  = 1'b0;
    repeat (3) @(posedge okClk);
    phase = "reset";
    #1 check_all();
    @(negedge okClk) reset_n = 1'b1;
    @(posedge okClk); #1;

    // Fill to full with 1..16, then read all back in order.
    phase = "order";
    for (int i = 1; i <= 16; i++) begin
      src_valid = 1'b1; src_data = 32'(i);
      step();
    end
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(src_ready), 32'd0);
    src_data = 32'h77; step();
    idle();
    for (int i = 1; i <= 16; i++) begin
      ep_read = 1'b1; step();
      chk("order_word", ep_datain, 32'(i));
      ep_read = 1'b0; step();
    end

    phase = "underflow";
    repeat (3) begin ep_read = 1'b1; step(); end
    chk("uf_word", ep_datain, 32'hDEAD_BEEF);
    chk("uf_cnt3", 32'(underflow_cnt), 32'd3);
    idle(); clear_err = 1'b1; step();
    chk("uf_cleared", 32'(underflow_cnt), 32'd0);
    idle();

    phase = "simul";
    for (int i = 0; i < 5; i++) begin src_valid = 1'b1; src_data = $urandom; step(); end
    for (int i = 0; i < 100; i++) begin
      src_valid = 1'b1; ep_read = 1'b1; src_data = $urandom; step();
    end
    chk("simul_level", 32'(level), 32'd5);
    src_valid = 1'b0;
    repeat (5) step();
    src_valid = 1'b1; src_data = 32'hCAFE_0001; step();
    chk("empty_pp_level", 32'(level), 32'd1);
    chk("empty_pp_word", ep_datain, 32'hDEAD_BEEF);
    src_valid = 1'b0; step();
    chk("empty_pp_stored", ep_datain, 32'hCAFE_0001);
    idle();

    phase = "flush";
    for (int i = 0; i < 10; i++) begin src_valid = 1'b1; src_data = $urandom; step(); end
    held = ep_datain;
    src_valid = 1'b1; ep_read = 1'b1; flush = 1'b1; src_data = 32'hBAD0_BAD0; step();
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_hold", ep_datain, held);
    idle(); ep_read = 1'b1; step();
    chk("flush_dropped", ep_datain, 32'hDEAD_BEEF);
    idle();

    phase = "clr_vs_uf";
    ep_read = 1'b1; clear_err = 1'b1; step();
    chk("clr_flag", 32'(underflow), 32'd0);
    idle();

    // Stream 3*DEPTH+7 words with random gaps on both sides.
    phase = "wrap";
    n_push = 0;
    budget = 2000;
    while ((n_push < 55 || q.size() > 0) && budget > 0) begin
      src_valid = (n_push < 55) && ($urandom_range(0, 3) != 0);
      src_data  = $urandom;
      ep_read   = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      if (src_valid && q.size() < 16) n_push++;
      step();
      chk("level_max", 32'(level <= 5'd16), 32'd1);
      budget--;
    end
    chk("wrap_done", 32'(budget > 0), 32'd1);
    idle();

    // Asynchronous reset in the middle of traffic with a pop pending.
    phase = "midreset";
    for (int i = 0; i < 6; i++) begin src_valid = 1'b1; src_data = $urandom; step(); end
    src_valid = 1'b0; ep_read = 1'b1; step();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    idle();
    @(negedge okClk) reset_n = 1'b1;
    @(posedge okClk); #1 check_all();
    ep_read = 1'b1; step();
    idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
